// File: rtl/ct_had_ddc_pkg.sv
// rtl/ct_had_ddc_pkg.sv - shared types and instruction constants for the HAD burst download channel
//
// Purpose: FSM state encoding and the fixed RISC-V instruction words injected
//          through the debug IR while draining the DDC data FIFO.
// Contents: ddc_state_e (3-bit), MV_X1, MV_X2, SD_X2_X1, SW_X2_X1,
//           ADDI_X1_4, ADDI_X1_8, store_insn(), incr_insn().

package ct_had_ddc_pkg;

   typedef enum logic [2:0] {
      DDC_IDLE  = 3'd0,
      DDC_ADDR  = 3'd1,
      DDC_DATA  = 3'd2,
      DDC_STORE = 3'd3,
      DDC_INCR  = 3'd4
   } ddc_state_e;

   // x1 holds the target address, x2 holds the data word; both are loaded
   // from WBBR by an "mv xN,xN" with the ffy transfer flag raised.
   localparam logic [31:0] MV_X1     = 32'h0000_8093;  // mv   x1,x1
   localparam logic [31:0] MV_X2     = 32'h0001_0113;  // mv   x2,x2
   localparam logic [31:0] SD_X2_X1  = 32'h0020_b023;  // sd   x2,0(x1)
   localparam logic [31:0] SW_X2_X1  = 32'h0020_a023;  // sw   x2,0(x1)
   localparam logic [31:0] ADDI_X1_4 = 32'h0040_8093;  // addi x1,x1,4
   localparam logic [31:0] ADDI_X1_8 = 32'h0080_8093;  // addi x1,x1,8

   function automatic logic [31:0] store_insn(input int dataw);
      return (dataw == 64) ? SD_X2_X1 : SW_X2_X1;
   endfunction

   function automatic logic [31:0] incr_insn(input int dataw);
      return (dataw == 64) ? ADDI_X1_8 : ADDI_X1_4;
   endfunction

endpackage

// File: rtl/ct_had_ddc_fifo.sv
// rtl/ct_had_ddc_fifo.sv - small synchronous FIFO holding DDC data words
//
// Purpose: DEPTH-entry circular buffer with head-of-queue read, synchronous
//          flush and asynchronous active-low reset.
// Ports:
//   cpuclk, cpurst_b   clock, async active-low reset
//   flush              empties the FIFO on the next edge (wins over push/pop)
//   push, wdata        write request; accepted when not full or popping
//   pop                removes the head entry; ignored when empty
//   rdata              current head entry
//   full, empty, cnt   occupancy status

module ct_had_ddc_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int PTRW = $clog2(DEPTH),
   localparam int CNTW = $clog2(DEPTH + 1)
) (
   input  logic             cpuclk,
   input  logic             cpurst_b,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNTW-1:0]  cnt
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNTW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNTW'(1);
            2'b01:   cnt <= cnt - CNTW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge cpuclk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ct_had_ddc_burst.sv
// rtl/ct_had_ddc_burst.sv - HAD debug download channel with burst data FIFO
//
// Purpose: JTAG loads DADDR once and streams DDATA words into a FIFO; an FSM
//          injects mv/mv/store/addi instructions through the debug IR and WBBR
//          to write each word to memory, advancing the address as it goes.
// Ports:
//   cpuclk, cpurst_b              clock, async active-low reset
//   x_sm_xx_update_dr_en          JTAG Update-DR pulse
//   ir_xx_daddr_reg_sel/ddata_reg_sel  scan register selects
//   ir_xx_wdata                   scan-chain data
//   had_ddc_en                    debug mode + DDC enabled; low aborts and flushes
//   ir_ddc_ack                    core finished the injected instruction
//   ddc_clr_err                   clears sticky ovf/aerr
//   ddc_regs_ir_vld/ir/wbbr/ffy   instruction-injection interface
//   ddc_regs_daddr                current address, zero-extended
//   ddc_busy, ddc_ovf, ddc_aerr, ddc_fifo_cnt  status

module ct_had_ddc_burst
   import ct_had_ddc_pkg::*;
#(
   parameter int DATAW    = 64,
   parameter int ADDRW    = 40,
   parameter int DEPTH    = 4,
   parameter int AUTO_INC = 1
) (
   input  logic                         cpuclk,
   input  logic                         cpurst_b,
   input  logic                         x_sm_xx_update_dr_en,
   input  logic                         ir_xx_daddr_reg_sel,
   input  logic                         ir_xx_ddata_reg_sel,
   input  logic [63:0]                  ir_xx_wdata,
   input  logic                         had_ddc_en,
   input  logic                         ir_ddc_ack,
   input  logic                         ddc_clr_err,
   output logic                         ddc_regs_ir_vld,
   output logic [31:0]                  ddc_regs_ir,
   output logic [63:0]                  ddc_regs_wbbr,
   output logic                         ddc_regs_ffy,
   output logic [63:0]                  ddc_regs_daddr,
   output logic                         ddc_busy,
   output logic                         ddc_ovf,
   output logic                         ddc_aerr,
   output logic [$clog2(DEPTH+1)-1:0]   ddc_fifo_cnt
);

   ddc_state_e        state_q;
   ddc_state_e        state_d;
   logic [ADDRW-1:0]  daddr_q;
   logic              addr_dirty_q;

   logic              ddata_wr;
   logic              daddr_wr;
   logic              daddr_ok;
   logic              ack_v;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATAW-1:0]  fifo_head;
   logic              addr_step;
   logic              addr_done;
   logic              ovf_set;
   logic              aerr_set;
   logic              unused_wdata;

   assign ddata_wr = x_sm_xx_update_dr_en & ir_xx_ddata_reg_sel;
   assign daddr_wr = x_sm_xx_update_dr_en & ir_xx_daddr_reg_sel;
   // DADDR may only move while nothing is queued against the old address.
   assign daddr_ok = daddr_wr & (state_q == DDC_IDLE) & fifo_empty;
   // Acks are meaningless once the channel has been disabled.
   assign ack_v    = ir_ddc_ack & had_ddc_en;
   assign ovf_set  = ddata_wr & fifo_full & ~fifo_pop;
   assign aerr_set = daddr_wr & ~daddr_ok;

   assign unused_wdata = ^ir_xx_wdata;

   ct_had_ddc_fifo #(
      .WIDTH (DATAW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .cpuclk   (cpuclk),
      .cpurst_b (cpurst_b),
      .flush    (~had_ddc_en),
      .push     (ddata_wr),
      .wdata    (ir_xx_wdata[DATAW-1:0]),
      .pop      (fifo_pop),
      .rdata    (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .cnt      (ddc_fifo_cnt)
   );

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state_q <= DDC_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      ddc_regs_ir   = 32'h0;
      ddc_regs_wbbr = 64'h0;
      ddc_regs_ffy  = 1'b0;
      fifo_pop      = 1'b0;
      addr_step     = 1'b0;
      addr_done     = 1'b0;
      case (state_q)
         DDC_IDLE: begin
            if (had_ddc_en && !fifo_empty)
               state_d = addr_dirty_q ? DDC_ADDR : DDC_DATA;
         end
         DDC_ADDR: begin
            ddc_regs_ir   = MV_X1;
            ddc_regs_wbbr = 64'(daddr_q);
            ddc_regs_ffy  = 1'b1;
            if (ack_v) begin
               state_d   = DDC_DATA;
               addr_done = 1'b1;
            end
         end
         DDC_DATA: begin
            ddc_regs_ir   = MV_X2;
            ddc_regs_wbbr = 64'(fifo_head);
            ddc_regs_ffy  = 1'b1;
            if (ack_v) state_d = DDC_STORE;
         end
         DDC_STORE: begin
            ddc_regs_ir = store_insn(DATAW);
            if (ack_v) begin
               fifo_pop = 1'b1;
               state_d  = (AUTO_INC != 0) ? DDC_INCR : DDC_IDLE;
            end
         end
         DDC_INCR: begin
            ddc_regs_ir = incr_insn(DATAW);
            if (ack_v) begin
               addr_step = 1'b1;
               state_d   = DDC_IDLE;
            end
         end
         default: state_d = DDC_IDLE;
      endcase
      if (!had_ddc_en) state_d = DDC_IDLE;
   end

   // x1 in the core may have been clobbered while the channel was disabled,
   // so the next burst must reload it.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         daddr_q      <= '0;
         addr_dirty_q <= 1'b1;
      end else begin
         if (daddr_ok)
            daddr_q <= ir_xx_wdata[ADDRW-1:0];
         else if (addr_step)
            daddr_q <= daddr_q + ADDRW'(DATAW / 8);

         if (!had_ddc_en || daddr_ok)
            addr_dirty_q <= 1'b1;
         else if (addr_done)
            addr_dirty_q <= 1'b0;
      end
   end

   // Sticky errors: a set in the same cycle as a clear wins.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ddc_ovf  <= 1'b0;
         ddc_aerr <= 1'b0;
      end else begin
         ddc_ovf  <= ovf_set  | (ddc_ovf  & ~ddc_clr_err);
         ddc_aerr <= aerr_set | (ddc_aerr & ~ddc_clr_err);
      end
   end

   assign ddc_regs_ir_vld = (state_q != DDC_IDLE);
   assign ddc_regs_daddr  = 64'(daddr_q);
   assign ddc_busy        = (state_q != DDC_IDLE) | (ddc_fifo_cnt != '0);

endmodule

// File: tb/tb_ct_had_ddc_burst.sv
// tb/tb_ct_had_ddc_burst.sv - self-checking bench for ct_had_ddc_burst
//
// Purpose: directed bursts against three configurations (64-bit auto-inc,
//          32-bit fixed address, 32-bit auto-inc) with an instruction scoreboard.

module tb_ct_had_ddc_burst;
   import ct_had_ddc_pkg::*;

   typedef struct {
      logic [31:0] ir;
      logic [63:0] wbbr;
      logic        ffy;
      logic        cw;
   } exp_t;

   logic        cpuclk = 1'b0;
   logic        cpurst_b = 1'b0;
   logic        upd = 1'b0;
   logic        asel = 1'b0;
   logic        dsel = 1'b0;
   logic [63:0] wdata = 64'h0;
   logic        had_en = 1'b1;
   logic        ack = 1'b0;
   logic        clr = 1'b0;
   int          sel = 0;

   int          errs = 0;
   int          checks = 0;
   exp_t        exp_q[$];

   logic        vld_k [3];
   logic [31:0] ir_k [3];
   logic [63:0] wbbr_k [3];
   logic        ffy_k [3];
   logic [63:0] daddr_k [3];
   logic        busy_k [3];
   logic        ovf_k [3];
   logic        aerr_k [3];
   logic [2:0]  cnt_k [3];

   logic        o_vld, o_ffy, o_busy, o_ovf, o_aerr;
   logic [31:0] o_ir;
   logic [63:0] o_wbbr, o_daddr;
   logic [2:0]  o_cnt;

   always #5 cpuclk = ~cpuclk;

   ct_had_ddc_burst #(.DATAW(64), .ADDRW(40), .DEPTH(4), .AUTO_INC(1)) u_dut64 (
      .cpuclk(cpuclk), .cpurst_b(cpurst_b), .x_sm_xx_update_dr_en(upd),
      .ir_xx_daddr_reg_sel(asel), .ir_xx_ddata_reg_sel(dsel), .ir_xx_wdata(wdata),
      .had_ddc_en(had_en), .ir_ddc_ack(ack && sel == 0), .ddc_clr_err(clr),
      .ddc_regs_ir_vld(vld_k[0]), .ddc_regs_ir(ir_k[0]), .ddc_regs_wbbr(wbbr_k[0]),
      .ddc_regs_ffy(ffy_k[0]), .ddc_regs_daddr(daddr_k[0]), .ddc_busy(busy_k[0]),
      .ddc_ovf(ovf_k[0]), .ddc_aerr(aerr_k[0]), .ddc_fifo_cnt(cnt_k[0]));

   ct_had_ddc_burst #(.DATAW(32), .ADDRW(40), .DEPTH(4), .AUTO_INC(0)) u_dut32 (
      .cpuclk(cpuclk), .cpurst_b(cpurst_b), .x_sm_xx_update_dr_en(upd),
      .ir_xx_daddr_reg_sel(asel), .ir_xx_ddata_reg_sel(dsel), .ir_xx_wdata(wdata),
      .had_ddc_en(had_en), .ir_ddc_ack(ack && sel == 1), .ddc_clr_err(clr),
      .ddc_regs_ir_vld(vld_k[1]), .ddc_regs_ir(ir_k[1]), .ddc_regs_wbbr(wbbr_k[1]),
      .ddc_regs_ffy(ffy_k[1]), .ddc_regs_daddr(daddr_k[1]), .ddc_busy(busy_k[1]),
      .ddc_ovf(ovf_k[1]), .ddc_aerr(aerr_k[1]), .ddc_fifo_cnt(cnt_k[1]));

   ct_had_ddc_burst #(.DATAW(32), .ADDRW(40), .DEPTH(4), .AUTO_INC(1)) u_dut32i (
      .cpuclk(cpuclk), .cpurst_b(cpurst_b), .x_sm_xx_update_dr_en(upd),
      .ir_xx_daddr_reg_sel(asel), .ir_xx_ddata_reg_sel(dsel), .ir_xx_wdata(wdata),
      .had_ddc_en(had_en), .ir_ddc_ack(ack && sel == 2), .ddc_clr_err(clr),
      .ddc_regs_ir_vld(vld_k[2]), .ddc_regs_ir(ir_k[2]), .ddc_regs_wbbr(wbbr_k[2]),
      .ddc_regs_ffy(ffy_k[2]), .ddc_regs_daddr(daddr_k[2]), .ddc_busy(busy_k[2]),
      .ddc_ovf(ovf_k[2]), .ddc_aerr(aerr_k[2]), .ddc_fifo_cnt(cnt_k[2]));

   always_comb begin
      o_vld   = vld_k[sel];
      o_ir    = ir_k[sel];
      o_wbbr  = wbbr_k[sel];
      o_ffy   = ffy_k[sel];
      o_daddr = daddr_k[sel];
      o_busy  = busy_k[sel];
      o_ovf   = ovf_k[sel];
      o_aerr  = aerr_k[sel];
      o_cnt   = cnt_k[sel];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic jtag_wr(input logic is_addr, input logic [63:0] d);
      upd   = 1'b1;
      asel  = is_addr;
      dsel  = ~is_addr;
      wdata = d;
      @(negedge cpuclk);
      upd   = 1'b0;
      asel  = 1'b0;
      dsel  = 1'b0;
   endtask

   task automatic push_e(input logic [31:0] ir, input logic [63:0] wb, input logic ffy, input logic cw);
      exp_t e;
      e.ir = ir; e.wbbr = wb; e.ffy = ffy; e.cw = cw;
      exp_q.push_back(e);
   endtask

   task automatic push_word(input logic [63:0] w, input int dw, input bit inc);
      logic [63:0] wm;
      wm = (dw == 64) ? w : {32'h0, w[31:0]};
      push_e(MV_X2, wm, 1'b1, 1'b1);
      push_e((dw == 64) ? SD_X2_X1 : SW_X2_X1, 64'h0, 1'b0, 1'b0);
      if (inc) push_e((dw == 64) ? ADDI_X1_8 : ADDI_X1_4, 64'h0, 1'b0, 1'b0);
   endtask

   task automatic wait_vld(input int budget);
      for (int i = 0; i < budget && !o_vld; i++) @(negedge cpuclk);
      chk("vld_seen", {63'h0, o_vld}, 64'h1);
   endtask

   // Pops one expected instruction, compares it, holds it for 'delay' cycles
   // to confirm it stays put, then acknowledges it.
   task automatic serve(input int delay);
      exp_t e;
      wait_vld(50);
      chk("sb_nonempty", {63'h0, exp_q.size() != 0}, 64'h1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("ir", {32'h0, o_ir}, {32'h0, e.ir});
      chk("ffy", {63'h0, o_ffy}, {63'h0, e.ffy});
      if (e.cw) chk("wbbr", o_wbbr, e.wbbr);
      repeat (delay) @(negedge cpuclk);
      if (delay > 0) chk("ir_stable", {32'h0, o_ir}, {32'h0, e.ir});
      ack = 1'b1;
      @(negedge cpuclk);
      ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      // Reset
      repeat (3) @(negedge cpuclk);
      cpurst_b = 1'b1;
      @(negedge cpuclk);
      chk("rst_vld", {63'h0, o_vld}, 64'h0);
      chk("rst_ir", {32'h0, o_ir}, 64'h0);
      chk("rst_wbbr", o_wbbr, 64'h0);
      chk("rst_ffy", {63'h0, o_ffy}, 64'h0);
      chk("rst_daddr", o_daddr, 64'h0);
      chk("rst_busy", {63'h0, o_busy}, 64'h0);
      chk("rst_ovf", {63'h0, o_ovf}, 64'h0);
      chk("rst_aerr", {63'h0, o_aerr}, 64'h0);
      chk("rst_cnt", {61'h0, o_cnt}, 64'h0);

      // Single 64-bit store with latency check
      jtag_wr(1'b1, 64'h8000_1000);
      chk("t1_daddr", o_daddr, 64'h8000_1000);
      push_e(MV_X1, 64'h8000_1000, 1'b1, 1'b1);
      jtag_wr(1'b0, 64'h1122_3344_5566_7788);
      push_word(64'h1122_3344_5566_7788, 64, 1'b1);
      chk("t1_cnt_n1", {61'h0, o_cnt}, 64'h1);
      chk("t1_vld_n1", {63'h0, o_vld}, 64'h0);
      @(negedge cpuclk);
      chk("t1_vld_n2", {63'h0, o_vld}, 64'h1);
      repeat (4) serve(0);
      chk("t1_daddr_end", o_daddr, 64'h8000_1008);
      chk("t1_busy_end", {63'h0, o_busy}, 64'h0);

      // Ack in IDLE does nothing
      ack = 1'b1;
      @(negedge cpuclk);
      ack = 1'b0;
      chk("idle_ack_vld", {63'h0, o_vld}, 64'h0);
      chk("idle_ack_daddr", o_daddr, 64'h8000_1008);

      // Burst of 3, slow acks, address stays loaded in x1
      for (int i = 0; i < 3; i++) begin
         jtag_wr(1'b0, 64'hA0A0_0000_0000_0000 + 64'(i));
         push_word(64'hA0A0_0000_0000_0000 + 64'(i), 64, 1'b1);
      end
      repeat (8) serve(5);
      chk("t2_busy_pre", {63'h0, o_busy}, 64'h1);
      serve(5);
      chk("t2_busy_end", {63'h0, o_busy}, 64'h0);
      chk("t2_cnt_end", {61'h0, o_cnt}, 64'h0);
      chk("t2_daddr_end", o_daddr, 64'h8000_1020);

      // Overflow with no acks
      for (int i = 0; i < 6; i++) begin
         jtag_wr(1'b0, 64'hB0B0_0000_0000_0000 + 64'(i));
         if (i < 4) push_word(64'hB0B0_0000_0000_0000 + 64'(i), 64, 1'b1);
      end
      chk("t3_cnt_full", {61'h0, o_cnt}, 64'h4);
      chk("t3_ovf", {63'h0, o_ovf}, 64'h1);
      clr = 1'b1;
      jtag_wr(1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
      clr = 1'b0;
      chk("t3_ovf_set_wins", {63'h0, o_ovf}, 64'h1);
      clr = 1'b1;
      @(negedge cpuclk);
      clr = 1'b0;
      chk("t3_ovf_clr", {63'h0, o_ovf}, 64'h0);
      chk("t3_cnt_still4", {61'h0, o_cnt}, 64'h4);
      repeat (12) serve(0);
      chk("t3_cnt_end", {61'h0, o_cnt}, 64'h0);
      chk("t3_daddr_end", o_daddr, 64'h8000_1040);

      // DADDR write while busy is rejected
      jtag_wr(1'b0, 64'hC0C0_0000_0000_0001);
      push_word(64'hC0C0_0000_0000_0001, 64, 1'b1);
      jtag_wr(1'b1, 64'hDEAD_0000);
      chk("t4_aerr", {63'h0, o_aerr}, 64'h1);
      chk("t4_daddr_hold", o_daddr, 64'h8000_1040);
      repeat (3) serve(0);
      chk("t4_daddr_end", o_daddr, 64'h8000_1048);
      clr = 1'b1;
      @(negedge cpuclk);
      clr = 1'b0;
      chk("t4_aerr_clr", {63'h0, o_aerr}, 64'h0);

      // Disable mid-DATA with two words queued
      jtag_wr(1'b0, 64'hF0F0_0000_0000_0000);
      jtag_wr(1'b0, 64'hF0F0_0000_0000_0001);
      wait_vld(20);
      chk("t5_in_data", {32'h0, o_ir}, {32'h0, MV_X2});
      chk("t5_cnt2", {61'h0, o_cnt}, 64'h2);
      had_en = 1'b0;
      ack = 1'b1;
      @(negedge cpuclk);
      ack = 1'b0;
      chk("t5_vld_off", {63'h0, o_vld}, 64'h0);
      chk("t5_flushed", {61'h0, o_cnt}, 64'h0);
      chk("t5_daddr_hold", o_daddr, 64'h8000_1048);
      chk("t5_busy_off", {63'h0, o_busy}, 64'h0);
      had_en = 1'b1;
      @(negedge cpuclk);
      push_e(MV_X1, 64'h8000_1048, 1'b1, 1'b1);
      jtag_wr(1'b0, 64'h5555_6666_7777_8888);
      push_word(64'h5555_6666_7777_8888, 64, 1'b1);
      repeat (4) serve(0);
      chk("t5_daddr_end", o_daddr, 64'h8000_1050);

      // 32-bit, fixed and auto-increment address at top of 40-bit space
      cpurst_b = 1'b0;
      repeat (2) @(negedge cpuclk);
      sel = 1;
      cpurst_b = 1'b1;
      @(negedge cpuclk);
      chk("t6_rst_daddr", o_daddr, 64'h0);
      jtag_wr(1'b1, 64'h0000_00FF_FFFF_FFFC);
      jtag_wr(1'b0, 64'h1234_5678_AABB_CCDD);
      jtag_wr(1'b0, 64'hFFFF_FFFF_0102_0304);
      push_e(MV_X1, 64'hFF_FFFF_FFFC, 1'b1, 1'b1);
      push_word(64'h1234_5678_AABB_CCDD, 32, 1'b0);
      push_word(64'hFFFF_FFFF_0102_0304, 32, 1'b0);
      repeat (5) serve(0);
      @(negedge cpuclk);
      chk("t6_no_incr", {63'h0, o_vld}, 64'h0);
      chk("t6_cnt_end", {61'h0, o_cnt}, 64'h0);
      chk("t6_daddr_fixed", o_daddr, 64'hFF_FFFF_FFFC);

      sel = 2;
      push_e(MV_X1, 64'hFF_FFFF_FFFC, 1'b1, 1'b1);
      push_word(64'h1234_5678_AABB_CCDD, 32, 1'b1);
      push_word(64'hFFFF_FFFF_0102_0304, 32, 1'b1);
      repeat (4) serve(0);
      chk("t6_daddr_wrap", o_daddr, 64'h0);
      repeat (3) serve(0);
      chk("t6_daddr_after", o_daddr, 64'h4);
      chk("t6_sb_drained", 64'(exp_q.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ct_had_ddc_burst.md
Name: ct_had_ddc_burst

Overview:
- Next-generation HAD debug download channel (DDC): JTAG loads an address once, then streams data words into a DEPTH-entry FIFO.
- An FSM injects the instruction sequence that stores each word to memory through the debug instruction register (IR) and the write-back buffer register (WBBR), advancing the address automatically.
- Generalised in data width (sw/sd), FIFO depth and auto-increment mode. Adds a CPU handshake and overflow/error status.
- Sits between the HAD JTAG IR/scan logic and the HAD register/instruction-injection path.

Parameters:
- DATAW, 64, store width; legal values 32 (sw) or 64 (sd).
- ADDRW, 40, physical address width (`PA_WIDTH`).
- DEPTH, 4, data FIFO entries; power of 2, at least 2.
- AUTO_INC, 1, 1 = advance address by DATAW/8 after each store; 0 = fixed address.

Ports:
- cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- x_sm_xx_update_dr_en  in  1  JTAG Update-DR pulse
- ir_xx_daddr_reg_sel  in  1  DADDR selected
- ir_xx_ddata_reg_sel  in  1  DDATA selected
- ir_xx_wdata  in  64  scan-chain data
- had_ddc_en  in  1  core in debug mode and DDC enabled
- ir_ddc_ack  in  1  core completed the injected instruction
- ddc_clr_err  in  1  clears sticky error bits
- ddc_regs_ir_vld  out  1  instruction valid
- ddc_regs_ir  out  32  injected instruction
- ddc_regs_wbbr  out  64  WBBR value
- ddc_regs_ffy  out  1  WBBR→GPR transfer flag
- ddc_regs_daddr  out  64  current address, zero-extended
- ddc_busy  out  1  FSM not IDLE, or FIFO non-empty
- ddc_ovf  out  1  sticky: data dropped because FIFO was full
- ddc_aerr  out  1  sticky: DADDR write rejected
- ddc_fifo_cnt  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async): FSM IDLE; FIFO empty; daddr 0; addr_dirty 1; ovf/aerr 0; ir_vld 0; ir 0; wbbr 0; ffy 0; busy 0.
- DDATA write (update_dr_en & ddata_sel):
  - pushes ir_xx_wdata[DATAW-1:0].
  - If full and no pop in the same cycle: word dropped, ovf set.
  - If full with a simultaneous pop: push accepted.
- DADDR write (update_dr_en & daddr_sel):
  - Accepted only when IDLE and FIFO empty: daddr <= wdata[ADDRW-1:0], addr_dirty <= 1.
  - Otherwise ignored and aerr set.
- FSM states: IDLE, ADDR, DATA, STORE, INCR. ir_vld = (state != IDLE).
  - IDLE: when had_en and FIFO non-empty → ADDR if addr_dirty, else DATA.
  - ADDR: ir = 0x00008093 (mv x1,x1); wbbr = zero-extended daddr; ffy = 1. On ack → DATA, addr_dirty <= 0.
  - DATA: ir = 0x00010113 (mv x2,x2); wbbr = zero-extended FIFO head; ffy = 1. On ack → STORE.
  - STORE: ir = 0x0020b023 (sd x2,0(x1)) when DATAW=64, 0x0020a023 (sw) when 32; ffy = 0. On ack: pop FIFO; → INCR if AUTO_INC, else IDLE.
  - INCR: ir = 0x00808093 (addi x1,x1,8) when DATAW=64, 0x00408093 when 32; ffy = 0. On ack: daddr <= daddr + DATAW/8 (wraps modulo 2^ADDRW); → IDLE.
- Outputs in IDLE: ir = 0, wbbr = 0.
- Outputs are combinational from the state and FIFO head; wbbr and ir are stable while vld is high and ack is absent.
- Latency: DDATA update in cycle N → FIFO count updates at N+1 → vld asserted in cycle N+2.
- had_ddc_en low in any state:
  - next edge goes to IDLE;
  - FIFO flushed;
  - addr_dirty <= 1, because x1 may be corrupted;
  - daddr holds its value;
  - a pending ack in that cycle is ignored.
- ack while IDLE: ignored.
- ddc_clr_err clears ovf and aerr. If a set event occurs in the same cycle, set wins.
- busy = (state != IDLE) | (fifo_cnt != 0).

Decomposition:
- Package ct_had_ddc_pkg:
  - FSM state encodings (3-bit);
  - instruction constants: MV_X1, MV_X2, SD_X2_X1, SW_X2_X1, ADDI_X1_4, ADDI_X1_8.
- Sub-module ct_had_ddc_fifo, parametrised by width and depth:
  - push/pop/full/empty/cnt;
  - head-of-queue read;
  - synchronous flush;
  - asynchronous reset.
- FSM, address register and status bits stay in the top module.

Test Plan:
- Single store, DATAW=64: DADDR=0x80001000, DDATA=0x1122334455667788, ack each cycle.
  → sequence 0x00008093 / wbbr 0x80001000; 0x00010113 / wbbr 0x1122334455667788; 0x0020b023; 0x00808093.
  → daddr ends 0x80001008.
- Burst of 3 words, ack delayed 5 cycles per instruction.
  → ADDR issued only once; DATA/STORE/INCR repeated 3×; daddr +24; FIFO drains to 0; busy drops after the final INCR ack.
- DEPTH=4, no ack, 6 DDATA writes.
  → fifo_cnt=4; ovf=1; first 4 words stored in order once acks resume; ddc_clr_err clears ovf.
- DADDR write while busy.
  → aerr=1; daddr unchanged; sequence completes correctly.
- had_ddc_en dropped mid-DATA with 2 words queued.
  → IDLE next cycle; FIFO empty; vld=0; after re-enable and a new DDATA, the sequence starts with ADDR.
- DATAW=32, AUTO_INC=0, DADDR=0xFFFFFFFFFC (ADDRW=40), 2 words.
  → STORE uses 0x0020a023; no INCR issued; daddr stays 0xFFFFFFFFFC.
  → separate run with AUTO_INC=1: daddr wraps to 0x0000000000.
